mem_interface_unit: RTL and testbench

Memory-side responder for the instruction unit's load/store handshake. Accepts a 14-bit-addressed load (one byte into operand register A or B) or store (16-bit ALU result) from the instruction unit. Executes the access on the byte-wide main-memory bus and returns read data plus a one-cycle `mem_done` pulse. Sits between the instruction unit and main memory inside the ALU593 top level.

---
 rtl/tinyalu_pkg.sv | 28 ++
 rtl/mem_interface_unit_if.sv | 31 +++
 rtl/mem_bus_watchdog.sv | 30 +++
 rtl/mem_interface_unit.sv | 155 +++++++++++++++
 tb/tb_mem_interface_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the ALU593 memory interface unit.
// FSM state enum, request bundle, bus widths and address helper.
package tinyalu_pkg;

   localparam int MEM_ADDR_W = 14;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_LO,
      WR_HI,
      DONE,
      RELEASE
   } miu_state_t;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0]   addr;
      logic [2*MEM_DATA_W-1:0] wdata;
   } miu_req_t;

   function automatic logic [MEM_ADDR_W-1:0] next_addr(
      input logic [MEM_ADDR_W-1:0] a
   );
      return a + MEM_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/mem_interface_unit_if.sv
// Byte-wide main-memory bus between the MIU and main memory.
// Signals: mem_req, mem_we, mem_addr, mem_wdata (master out), mem_rdata, mem_ack (slave out).
interface mem_interface_unit_if;
   import tinyalu_pkg::*;

   logic                  mem_req;
   logic                  mem_we;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [MEM_DATA_W-1:0] mem_wdata;
   logic [MEM_DATA_W-1:0] mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/mem_bus_watchdog.sv
// Bus wait counter: pulses timeout when an un-acked beat hits LIMIT cycles.
// Ports: clk, reset, active, ack, restart in; timeout out. Built only with MIU_TIMEOUT_EN.
`ifdef MIU_TIMEOUT_EN
module mem_bus_watchdog #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ack,
   input  logic restart,
   output logic timeout
);

   logic [7:0] cnt;

   // Fires in the last allowed wait cycle so the request drops
   // after exactly LIMIT cycles; an ack in that cycle still wins.
   assign timeout = active && !ack && (cnt == 8'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         cnt <= '0;
      end else if (active && !ack) begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule
`endif

// File: rtl/mem_interface_unit.sv
// Memory-side responder: runs IU loads/stores on the byte bus, pulses mem_done.
// Ports: clk, reset, load, store, addr, result, data, mem_done, mem_err, bus (master). Option: MIU_TIMEOUT_EN.
module mem_interface_unit
   import tinyalu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    store,
   input  logic [MEM_ADDR_W-1:0]   addr,
   input  logic [2*MEM_DATA_W-1:0] result,
   output logic [MEM_DATA_W-1:0]   data,
   output logic                    mem_done,
   output logic                    mem_err,
   mem_interface_unit_if.master    bus
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   miu_state_t state;
   miu_state_t state_nx;
   miu_req_t   req_q;
   logic       timeout;

`ifdef MIU_TIMEOUT_EN
   logic active;
   logic restart;
   logic err_q;

   assign active  = (state == RD) || (state == WR_LO) ||
                    (state == WR_HI);
   // Any state change is a state entry, so the counter restarts.
   assign restart = (state_nx != state);

   mem_bus_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .active (active),
      .ack    (bus.mem_ack),
      .restart(restart),
      .timeout(timeout)
   );

   // timeout only pulses on the edge into DONE, so err_q is high
   // exactly during the DONE cycle that follows an abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= timeout;
      end
   end

   assign mem_err = (state == DONE) && err_q;
`else
   assign timeout = 1'b0;
   assign mem_err = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (load) begin
               state_nx = RD;
            end else if (store) begin
               state_nx = WR_LO;
            end
         end
         RD: begin
            if (bus.mem_ack || timeout) begin
               state_nx = DONE;
            end
         end
         WR_LO: begin
            if (bus.mem_ack) begin
               state_nx = WR_HI;
            end else if (timeout) begin
               state_nx = DONE;
            end
         end
         WR_HI: begin
            if (bus.mem_ack || timeout) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = RELEASE;
         end
         RELEASE: begin
            // Level requests stay high until seen done; wait them out.
            if (!load && !store) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         req_q <= '0;
         data  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && (load || store)) begin
            req_q <= '{addr: addr, wdata: result};
         end
         if (state == RD && bus.mem_ack) begin
            data <= bus.mem_rdata;
         end
      end
   end

   // Bus outputs decode from state and captured request only, so
   // they hold steady through every wait cycle of a beat.
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         RD: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = req_q.addr;
         end
         WR_LO: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = req_q.addr;
            bus.mem_wdata = req_q.wdata[MEM_DATA_W-1:0];
         end
         WR_HI: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = next_addr(req_q.addr);
            bus.mem_wdata = req_q.wdata[2*MEM_DATA_W-1:MEM_DATA_W];
         end
         default: begin
         end
      endcase
   end

   assign mem_done = (state == DONE);

endmodule

// File: tb/tb_mem_interface_unit.sv
// Scoreboard bench for mem_interface_unit with a random-wait memory model.
// Covers loads, stores, wrap, level hold, load/store priority, reset abort, MIU_TIMEOUT_EN.
module tb_mem_interface_unit;
   import tinyalu_pkg::*;

   localparam int TO = 4;

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wd;
   } bus_t;

   typedef struct {
      logic [7:0] data;
      logic       err;
   } done_t;

   logic        clk;
   logic        reset;
   logic        load;
   logic        store;
   logic [13:0] addr;
   logic [15:0] result;
   logic [7:0]  data;
   logic        mem_done;
   logic        mem_err;

   mem_interface_unit_if bus ();

   mem_interface_unit #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .store   (store),
      .addr    (addr),
      .result  (result),
      .data    (data),
      .mem_done(mem_done),
      .mem_err (mem_err),
      .bus     (bus)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   bus_t  bus_q[$];
   done_t done_q[$];
   logic [7:0] ref_mem [16384];
   logic [7:0] smem [16384];
   logic [7:0] last_data;
   int    wt[2];
   int    beat;
   int    wc;
   bit    stray_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic bus_t mk_bus(input logic we, input logic [13:0] a,
                                   input logic [7:0] wd);
      bus_t b;
      b.we = we;
      b.addr = a;
      b.wd = wd;
      return b;
   endfunction

   function automatic done_t mk_done(input logic [7:0] d, input logic e);
      done_t x;
      x.data = d;
      x.err = e;
      return x;
   endfunction

   // Memory slave: ack after wt[beat] wait cycles, stray acks when idle.
   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 8'h00;
      wc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req) begin
            if (wc >= wt[beat]) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) begin
                  smem[bus.mem_addr] = bus.mem_wdata;
                  bus.mem_rdata = 8'($urandom);
               end else begin
                  bus.mem_rdata = smem[bus.mem_addr];
               end
               wc = 0;
               if (beat < 1) beat++;
            end else begin
               bus.mem_ack = 1'b0;
               bus.mem_rdata = 8'($urandom);
               wc++;
            end
         end else begin
            wc = 0;
            bus.mem_rdata = 8'($urandom);
            bus.mem_ack = stray_en && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Bus monitor: every request cycle must match the expected beat.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (bus_q.size() == 0) begin
            check("bus_unexpected", {31'd0, bus.mem_req}, 32'd0);
         end else begin
            check("bus_beat",
                  {9'd0, bus.mem_we, bus.mem_addr,
                   bus.mem_we ? bus.mem_wdata : 8'h00},
                  {9'd0, bus_q[0].we, bus_q[0].addr, bus_q[0].wd});
            if (bus.mem_ack) void'(bus_q.pop_front());
         end
      end
   end

   // Completion monitor: each mem_done pops one expected response.
   always @(negedge clk) begin
      if (mem_done) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", {31'd0, mem_done}, 32'd0);
         end else begin
            check("done_data", {24'd0, data}, {24'd0, done_q[0].data});
            check("done_err", {31'd0, mem_err}, {31'd0, done_q[0].err});
            void'(done_q.pop_front());
         end
      end else if (mem_err) begin
         check("err_without_done", {31'd0, mem_err}, 32'd0);
      end
   end

   task automatic run_req(input bit ld, input bit st,
                          input logic [13:0] a, input logic [15:0] r,
                          input int w0, input int w1,
                          input int hold, input bit to);
      int n;
      int nreq;
      int lat;
      int req_exp;
      logic [13:0] a1;
      a1 = a + 14'd1;
      wt[0] = w0;
      wt[1] = w1;
      beat = 0;
      if (ld) begin
         bus_q.push_back(mk_bus(1'b0, a, 8'h00));
         if (to) begin
            done_q.push_back(mk_done(last_data, 1'b1));
            lat = 1 + TO;
            req_exp = TO;
         end else begin
            last_data = ref_mem[a];
            done_q.push_back(mk_done(last_data, 1'b0));
            lat = 2 + w0;
            req_exp = 1 + w0;
         end
      end else begin
         bus_q.push_back(mk_bus(1'b1, a, r[7:0]));
         bus_q.push_back(mk_bus(1'b1, a1, r[15:8]));
         ref_mem[a] = r[7:0];
         ref_mem[a1] = r[15:8];
         done_q.push_back(mk_done(last_data, 1'b0));
         lat = 3 + w0 + w1;
         req_exp = 2 + w0 + w1;
      end
      load = ld;
      store = st;
      addr = a;
      result = r;
      n = 0;
      nreq = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            addr = 14'($urandom);
            result = 16'($urandom);
         end
         if (bus.mem_req) nreq++;
      end while (!mem_done && n < 300);
      check("latency", n, lat);
      check("req_cycles", nreq, req_exp);
      if (to && bus_q.size() > 0) void'(bus_q.pop_front());
      repeat (hold) @(negedge clk);
      load = 1'b0;
      store = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_wr_hi(input logic [13:0] a,
                                  input logic [15:0] r);
      logic [13:0] a1;
      int n;
      a1 = a + 14'd1;
      wt[0] = 0;
      wt[1] = 3;
      beat = 0;
      bus_q.push_back(mk_bus(1'b1, a, r[7:0]));
      bus_q.push_back(mk_bus(1'b1, a1, r[15:8]));
      ref_mem[a] = r[7:0];
      store = 1'b1;
      addr = a;
      result = r;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.mem_req && bus.mem_we && bus.mem_addr == a1)
                 && n < 20);
      check("reach_wr_hi", {31'd0, n < 20}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_done", {31'd0, mem_done}, 32'd0);
      check("rst_data", {24'd0, data}, 32'd0);
      bus_q.delete();
      last_data = 8'h00;
      store = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [7:0] v;
      bit ld;
      bit st;
      logic [13:0] a;
      reset = 1'b1;
      load = 1'b0;
      store = 1'b0;
      addr = '0;
      result = '0;
      stray_en = 1'b0;
      beat = 0;
      wt[0] = 0;
      wt[1] = 0;
      last_data = 8'h00;
      for (int i = 0; i < 16384; i++) begin
         v = 8'($urandom);
         smem[i] = v;
         ref_mem[i] = v;
      end
      smem[14'h0123] = 8'hA5;
      ref_mem[14'h0123] = 8'hA5;

      repeat (3) @(negedge clk);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_done", {31'd0, mem_done}, 32'd0);
      check("reset_err", {31'd0, mem_err}, 32'd0);
      check("reset_req", {31'd0, bus.mem_req}, 32'd0);
      check("reset_we", {31'd0, bus.mem_we}, 32'd0);
      check("reset_addr", {18'd0, bus.mem_addr}, 32'd0);
      check("reset_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_req(1'b1, 1'b0, 14'h0123, 16'h0000, 2, 0, 0, 1'b0);
      check("load_a5", {24'd0, data}, 32'h0000_00A5);
      run_req(1'b0, 1'b1, 14'h0040, 16'hBEEF, 0, 0, 0, 1'b0);
      run_req(1'b0, 1'b1, 14'h3FFF, 16'h1234, 0, 0, 0, 1'b0);
      run_req(1'b1, 1'b0, 14'h3FFF, 16'h0000, 1, 0, 0, 1'b0);
      run_req(1'b1, 1'b0, 14'h0000, 16'h0000, 0, 0, 10, 1'b0);
      run_req(1'b1, 1'b1, 14'h0041, 16'h5A5A, 1, 0, 0, 1'b0);
      reset_mid_wr_hi(14'h1ABC, 16'hC0DE);
      run_req(1'b1, 1'b0, 14'h1ABC, 16'h0000, 0, 0, 0, 1'b0);
`ifdef MIU_TIMEOUT_EN
      run_req(1'b1, 1'b0, 14'h0200, 16'h0000, 100, 0, 0, 1'b1);
      check("timeout_data_kept", {24'd0, data}, {24'd0, last_data});
`endif

      stray_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0: begin ld = 1'b1; st = 1'b0; end
            1: begin ld = 1'b0; st = 1'b1; end
            2: begin ld = 1'b1; st = 1'b1; end
            default: begin ld = 1'b0; st = 1'b1; end
         endcase
         a = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
         run_req(ld, st, a, 16'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
      stray_en = 1'b0;
      repeat (4) @(negedge clk);

      check("bus_q_drained", bus_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
